// File: rtl/mem_arbiter_if.sv
// Bundle for the fetch port, the load/store port and the single-port RAM
// around mem_arbiter; the arbiter uses the slave modport and the surrounding system uses the master modport.
interface mem_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic          ifu_req;
    logic [AW-1:0] ifu_addr;
    logic          ifu_gnt;
    logic          ifu_rvalid;
    logic [DW-1:0] ifu_rdata;

    logic          lsu_req;
    logic          lsu_we;
    logic [AW-1:0] lsu_addr;
    logic [SW-1:0] lsu_sel;
    logic [DW-1:0] lsu_wdata;
    logic          lsu_gnt;
    logic          lsu_rvalid;
    logic [DW-1:0] lsu_rdata;

    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_sel;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          stall_o;

    modport slave (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_we, lsu_addr, lsu_sel, lsu_wdata,
        input  mem_rdata,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
        output stall_o
    );

    modport master (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_we, lsu_addr, lsu_sel, lsu_wdata,
        output mem_rdata,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
        input  stall_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (LSU over IFU) arbiter for one synchronous single-port RAM.
// Optional macro STARVE_GUARD_EN forces an IFU win after STARVE_MAX denied cycles.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_LS = 2'd2,
        WR_LS = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_ifu_gnt;
    logic          w_lsu_gnt;
    logic          w_force_ifu;
    logic          w_mem_ce;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [SW-1:0] w_mem_sel;
    logic [DW-1:0] w_mem_wdata;
    logic          w_ifu_rvalid;
    logic          w_lsu_rvalid;

`ifdef STARVE_GUARD_EN
    logic [CW-1:0] r_starve_cnt;

    // Counts consecutive denied fetch cycles, saturating at STARVE_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!bus.ifu_req || w_ifu_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != CW'(STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end
    end

    assign w_force_ifu = (r_starve_cnt == CW'(STARVE_MAX));
`else
    logic w_unused_starve;
    assign w_unused_starve = ^CW'(STARVE_MAX);
    assign w_force_ifu     = 1'b0;
`endif

    // Grants are held low during reset so every output reads 0.
    always_comb begin
        w_ifu_gnt = 1'b0;
        w_lsu_gnt = 1'b0;
        if (rst_n) begin
            if (bus.lsu_req && !(bus.ifu_req && w_force_ifu)) begin
                w_lsu_gnt = 1'b1;
            end else if (bus.ifu_req) begin
                w_ifu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_mem_ce    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_sel   = '0;
        w_mem_wdata = '0;
        w_state_nxt = IDLE;
        if (w_lsu_gnt) begin
            w_mem_ce    = 1'b1;
            w_mem_we    = bus.lsu_we;
            w_mem_addr  = bus.lsu_addr;
            w_mem_sel   = bus.lsu_sel;
            w_mem_wdata = bus.lsu_wdata;
            w_state_nxt = bus.lsu_we ? WR_LS : RD_LS;
        end else if (w_ifu_gnt) begin
            w_mem_ce    = 1'b1;
            w_mem_addr  = bus.ifu_addr;
            w_mem_sel   = '1;
            w_state_nxt = RD_IF;
        end
    end

    // Records which access is in flight; reset discards a pending read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_ifu_rvalid = (r_state == RD_IF);
    assign w_lsu_rvalid = (r_state == RD_LS);

    assign bus.ifu_gnt    = w_ifu_gnt;
    assign bus.lsu_gnt    = w_lsu_gnt;
    assign bus.ifu_rvalid = w_ifu_rvalid;
    assign bus.lsu_rvalid = w_lsu_rvalid;
    assign bus.ifu_rdata  = w_ifu_rvalid ? bus.mem_rdata : '0;
    assign bus.lsu_rdata  = w_lsu_rvalid ? bus.mem_rdata : '0;
    assign bus.mem_ce     = w_mem_ce;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_sel    = w_mem_sel;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.stall_o    = rst_n && bus.ifu_req && !w_ifu_gnt;
endmodule
